// File: rtl/assert_ctrl_pkg.sv
// assert_ctrl_pkg
// Shared types for the assertion-control monitor: control op codes,
// directive-type mask bits, command FSM states and an op-legality helper.
// No ports (package).
package assert_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NONE         = 4'd0,
    OP_LOCK         = 4'd1,
    OP_UNLOCK       = 4'd2,
    OP_ON           = 4'd3,
    OP_OFF          = 4'd4,
    OP_KILL         = 4'd5,
    OP_PASSON       = 4'd6,
    OP_PASSOFF      = 4'd7,
    OP_FAILON       = 4'd8,
    OP_FAILOFF      = 4'd9,
    OP_NONVACUOUSON = 4'd10,
    OP_VACUOUSOFF   = 4'd11,
    OP_CLRCNT       = 4'd12
  } ctrl_op_e;

  localparam logic [1:0] DIR_ASSERT = 2'd1;
  localparam logic [1:0] DIR_COVER  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_APPLY = 2'd2
  } fsm_state_e;

  function automatic logic op_supported(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd12);
  endfunction

endpackage

// File: rtl/assert_ctrl_unit_chan.sv
// assert_ctrl_chan
// One monitored channel: evaluates "ant |=> con" as an assert or a cover,
// holds the runtime control flags and a saturating event counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ant, con          antecedent / consequent for this channel
//   apply, sel, op    command apply strobe, channel selected, op code
//   pass_p, vac_p,    registered one-cycle result pulses
//   fail_p
//   cnt               fail (assert) / hit (cover) counter
module assert_ctrl_chan
  import assert_ctrl_pkg::*;
#(
  parameter bit IS_COVER = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ant,
  input  logic             con,
  input  logic             apply,
  input  logic             sel,
  input  logic [3:0]       op,
  output logic             pass_p,
  output logic             vac_p,
  output logic             fail_p,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic en, lock, pass_en, fail_en, vac_en;
  logic pend;   // non-vacuous attempt waiting for its consequent
  logic vpend;  // vacuous attempt (ant=0) waiting to report
  logic act, kill, evt;

  always_comb begin
    // a locked channel only listens to UNLOCK
    act  = apply && sel && (!lock || (op == OP_UNLOCK));
    kill = act && (op == OP_KILL);
    // counter event is independent of output gating
    evt  = pend && !kill && (IS_COVER ? con : !con);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b1;
      lock    <= 1'b0;
      pass_en <= 1'b1;
      fail_en <= 1'b1;
      vac_en  <= 1'b1;
      pend    <= 1'b0;
      vpend   <= 1'b0;
      pass_p  <= 1'b0;
      vac_p   <= 1'b0;
      fail_p  <= 1'b0;
      cnt     <= '0;
    end else begin
      // evaluation and attempt start use pre-op flags; only KILL acts on this edge
      pass_p <= pend && !kill && con && pass_en;
      fail_p <= !IS_COVER && pend && !kill && !con && fail_en;
      vac_p  <= vpend && !kill && vac_en;
      pend   <= en && ant && !kill;
      vpend  <= !IS_COVER && en && !ant && !kill;

      if (act && (op == OP_CLRCNT)) begin
        cnt <= '0;
      end else if (evt && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (act) begin
        case (op)
          OP_LOCK:         lock    <= 1'b1;
          OP_UNLOCK:       lock    <= 1'b0;
          OP_ON:           en      <= 1'b1;
          OP_OFF:          en      <= 1'b0;
          OP_PASSON:       pass_en <= 1'b1;
          OP_PASSOFF:      pass_en <= 1'b0;
          OP_FAILON:       fail_en <= 1'b1;
          OP_FAILOFF:      fail_en <= 1'b0;
          // both vacuity ops silence vacuous passes; only reset restores them
          OP_NONVACUOUSON: vac_en  <= 1'b0;
          OP_VACUOUSOFF:   vac_en  <= 1'b0;
          default:         ;
        endcase
      end
    end
  end

endmodule

// File: rtl/assert_ctrl_unit.sv
// assert_ctrl_unit
// Multi-channel "a |=> b" property monitor with runtime control modelled
// on $assertcontrol. Commands are latched on accept, optionally delayed,
// then applied for one cycle to the channels picked by index and type.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ant_i, con_i               per-channel antecedent / consequent
//   cmd_valid, cmd_ready       command handshake (ready only when idle)
//   cmd_op, cmd_dir, cmd_ch,   op code, directive mask, channel mask,
//   cmd_dly                    apply delay in cycles
//   pass_o, vac_o, fail_o      per-channel one-cycle result pulses
//   rd_sel, rd_cnt             counter read-back mux
//   cmd_err                    unsupported op reached the apply cycle
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | ready for a command
// ST_WAIT  | delay down-counter running, command fields held
// ST_APPLY | one cycle: op takes effect on the closing edge
module assert_ctrl_unit
  import assert_ctrl_pkg::*;
#(
  parameter int                NUM_CH      = 8,
  parameter logic [NUM_CH-1:0] CH_IS_COVER = '0,
  parameter int                CNT_W       = 16,
  parameter int                DLY_W       = 8,
  localparam int               SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ant_i,
  input  logic [NUM_CH-1:0] con_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [1:0]        cmd_dir,
  input  logic [NUM_CH-1:0] cmd_ch,
  input  logic [DLY_W-1:0]  cmd_dly,
  output logic [NUM_CH-1:0] pass_o,
  output logic [NUM_CH-1:0] vac_o,
  output logic [NUM_CH-1:0] fail_o,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              cmd_err
);

  fsm_state_e        state_q, state_d;
  logic [3:0]        op_q;
  logic [1:0]        dir_q;
  logic [NUM_CH-1:0] ch_q;
  logic [DLY_W-1:0]  dly_q;
  logic              accept, apply;
  logic [NUM_CH-1:0] sel;
  logic [CNT_W-1:0]  cnt_arr [NUM_CH];

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    apply     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_dly == '0) ? ST_APPLY : ST_WAIT;
      end
      // terminal count at 1 so dly=N lands the apply edge N+1 edges after accept
      ST_WAIT:  if (dly_q == DLY_W'(1)) state_d = ST_APPLY;
      ST_APPLY: begin
        apply   = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign accept  = cmd_valid && cmd_ready;
  assign cmd_err = apply && !op_supported(op_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dir_q   <= '0;
      ch_q    <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= cmd_op;
        dir_q <= cmd_dir;
        ch_q  <= cmd_ch;
        dly_q <= cmd_dly;
      end else if (state_q == ST_WAIT) begin
        dly_q <= dly_q - DLY_W'(1);
      end
    end
  end

  // zero masks mean "all"; each channel answers to the dir bit of its own type
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = ((ch_q == '0) || ch_q[i]) &&
               ((dir_q == '0) ||
                (CH_IS_COVER[i] ? |(dir_q & DIR_COVER) : |(dir_q & DIR_ASSERT)));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assert_ctrl_chan #(
      .IS_COVER (CH_IS_COVER[g]),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .ant    (ant_i[g]),
      .con    (con_i[g]),
      .apply  (apply),
      .sel    (sel[g]),
      .op     (op_q),
      .pass_p (pass_o[g]),
      .vac_p  (vac_o[g]),
      .fail_p (fail_o[g]),
      .cnt    (cnt_arr[g])
    );
  end

  // out-of-range indices read as zero
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_cnt = cnt_arr[i];
    end
  end

endmodule

// File: tb/tb_assert_ctrl_unit.sv
// tb_assert_ctrl_unit
// Directed self-checking bench for assert_ctrl_unit (8 channels, ch3 is a
// cover, 4-bit counters). Inputs change 1 time unit after a rising edge and
// outputs are sampled there too, so each tick() observes exactly one edge.
module tb_assert_ctrl_unit;

  logic       clk, rst;
  logic [7:0] ant, con;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_dir;
  logic [7:0] cmd_ch, cmd_dly;
  logic [7:0] pass_o, vac_o, fail_o;
  logic [2:0] rd_sel;
  logic [3:0] rd_cnt;
  logic       cmd_err;

  int checks   = 0;
  int failures = 0;

  assert_ctrl_unit #(
    .NUM_CH(8), .CH_IS_COVER(8'h08), .CNT_W(4), .DLY_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ant_i(ant), .con_i(con),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dir(cmd_dir), .cmd_ch(cmd_ch), .cmd_dly(cmd_dly),
    .pass_o(pass_o), .vac_o(vac_o), .fail_o(fail_o),
    .rd_sel(rd_sel), .rd_cnt(rd_cnt), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] dir,
                      input logic [7:0] ch, input logic [7:0] dly);
    int n;
    n = 0;
    while ((cmd_ready !== 1'b1) && (n < 100)) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL send_ready_timeout got=%b exp=1", cmd_ready);
    end
    cmd_op = op; cmd_dir = dir; cmd_ch = ch; cmd_dly = dly;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [1:0] dir,
                        input logic [7:0] ch, input logic [7:0] dly);
    send(op, dir, ch, dly);
    repeat (int'(dly) + 1) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ant = '0; con = '0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_dir = '0; cmd_ch = '0; cmd_dly = '0; rd_sel = '0;
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++;
    if ({pass_o, vac_o, fail_o} !== 24'h0) begin
      failures++; $display("FAIL reset_pulses got=%h exp=000000", {pass_o, vac_o, fail_o});
    end
    checks++;
    if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cmd_err); end
    checks++;
    if (rd_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", rd_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_pass_fail();
    ant = 8'h01; tick();
    ant = 8'h00; con = 8'h01; tick();
    checks++;
    if (pass_o !== 8'h01) begin failures++; $display("FAIL pass_ch0 got=%h exp=01", pass_o); end
    checks++;
    if (vac_o !== 8'hF6) begin failures++; $display("FAIL vac_others got=%h exp=f6", vac_o); end
    con = 8'h00; tick();
    checks++;
    if (pass_o !== 8'h00) begin failures++; $display("FAIL pass_one_cycle got=%h exp=00", pass_o); end
    ant = 8'h01; tick();
    ant = 8'h00; tick();
    checks++;
    if (fail_o !== 8'h01) begin failures++; $display("FAIL fail_ch0 got=%h exp=01", fail_o); end
    checks++;
    if (rd_cnt !== 4'd1) begin failures++; $display("FAIL cnt_after_fail got=%0d exp=1", rd_cnt); end
  endtask

  task automatic test_delay_off();
    int bad;
    bad = 0;
    send(4'd4, 2'd0, 8'h00, 8'd20);
    for (int j = 0; j <= 20; j++) begin
      if (cmd_ready !== 1'b0) bad++;
      if (j == 19) ant = 8'h01;
      if (j == 20) ant = 8'h00;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL ready_low_21 got=%0d_high exp=0_high", bad); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_apply got=%b exp=1", cmd_ready); end
    checks++;
    if (fail_o !== 8'h01) begin failures++; $display("FAIL inflight_at_off got=%h exp=01", fail_o); end
    ant = 8'hFF; tick();
    ant = 8'h00; tick();
    checks++;
    if ({pass_o, vac_o, fail_o} !== 24'h0) begin
      failures++; $display("FAIL off_silent got=%h exp=000000", {pass_o, vac_o, fail_o});
    end
  endtask

  task automatic test_lock();
    do_cmd(4'd3, 2'd0, 8'h00, 8'd0);
    do_cmd(4'd1, 2'd0, 8'h01, 8'd0);
    do_cmd(4'd4, 2'd0, 8'h00, 8'd0);
    do_cmd(4'd2, 2'd0, 8'h01, 8'd0);
    ant = 8'hFF; tick();
    ant = 8'h00; con = 8'h00; tick();
    checks++;
    if (fail_o !== 8'h01) begin failures++; $display("FAIL lock_keeps_ch0 got=%h exp=01", fail_o); end
    checks++;
    if (rd_cnt !== 4'd3) begin failures++; $display("FAIL lock_cnt got=%0d exp=3", rd_cnt); end
  endtask

  task automatic test_dir();
    do_cmd(4'd3, 2'd1, 8'h08, 8'd0);
    ant = 8'h08; tick();
    ant = 8'h00; con = 8'h08; tick();
    checks++;
    if (pass_o !== 8'h00) begin failures++; $display("FAIL dir_assert_skips_cover got=%h exp=00", pass_o); end
    con = 8'h00;
    do_cmd(4'd3, 2'd2, 8'h08, 8'd0);
    ant = 8'h08; tick();
    ant = 8'h00; con = 8'h08; tick();
    checks++;
    if (pass_o !== 8'h08) begin failures++; $display("FAIL cover_hit got=%h exp=08", pass_o); end
    con = 8'h00;
    ant = 8'h08; tick();
    ant = 8'h00; tick();
    checks++;
    if ({pass_o, fail_o} !== 16'h0) begin failures++; $display("FAIL cover_miss_silent got=%h exp=0000", {pass_o, fail_o}); end
    rd_sel = 3'd3; #1;
    checks++;
    if (rd_cnt !== 4'd1) begin failures++; $display("FAIL cover_cnt got=%0d exp=1", rd_cnt); end
    rd_sel = 3'd0;
  endtask

  task automatic test_kill_gating();
    ant = 8'h01; cmd_op = 4'd5; cmd_dir = 2'd0; cmd_ch = 8'h01; cmd_dly = 8'd0;
    cmd_valid = 1'b1; tick();
    cmd_valid = 1'b0; ant = 8'h00; con = 8'h00; tick();
    checks++;
    if (fail_o !== 8'h00) begin failures++; $display("FAIL kill_no_fail got=%h exp=00", fail_o); end
    checks++;
    if (rd_cnt !== 4'd3) begin failures++; $display("FAIL kill_cnt got=%0d exp=3", rd_cnt); end
    ant = 8'h01; tick();
    ant = 8'h00; tick();
    checks++;
    if (fail_o !== 8'h01) begin failures++; $display("FAIL after_kill_fail got=%h exp=01", fail_o); end
    tick();
    checks++;
    if (vac_o !== 8'h01) begin failures++; $display("FAIL vac_before_off got=%h exp=01", vac_o); end
    do_cmd(4'd11, 2'd0, 8'h01, 8'd0);
    tick(); tick();
    checks++;
    if (vac_o !== 8'h00) begin failures++; $display("FAIL vacuousoff got=%h exp=00", vac_o); end
    do_cmd(4'd9, 2'd0, 8'h01, 8'd0);
    ant = 8'h01; tick();
    ant = 8'h00; tick();
    checks++;
    if (fail_o !== 8'h00) begin failures++; $display("FAIL failoff_pulse got=%h exp=00", fail_o); end
    checks++;
    if (rd_cnt !== 4'd5) begin failures++; $display("FAIL failoff_cnt got=%0d exp=5", rd_cnt); end
  endtask

  task automatic test_back_to_back_sat();
    do_cmd(4'd8, 2'd0, 8'h01, 8'd0);
    do_cmd(4'd12, 2'd0, 8'h01, 8'd0);
    checks++;
    if (rd_cnt !== 4'd0) begin failures++; $display("FAIL clrcnt got=%0d exp=0", rd_cnt); end
    con = 8'h00; ant = 8'h01;
    repeat (17) tick();
    ant = 8'h00; tick();
    checks++;
    if (rd_cnt !== 4'd15) begin failures++; $display("FAIL saturate got=%0d exp=15", rd_cnt); end
    checks++;
    if (fail_o !== 8'h01) begin failures++; $display("FAIL b2b_fail got=%h exp=01", fail_o); end
  endtask

  task automatic test_bad_op();
    send(4'd13, 2'd0, 8'h00, 8'd0);
    checks++;
    if ({cmd_err, cmd_ready} !== 2'b10) begin failures++; $display("FAIL bad_op_err got=%b exp=10", {cmd_err, cmd_ready}); end
    tick();
    checks++;
    if ({cmd_err, cmd_ready} !== 2'b01) begin failures++; $display("FAIL bad_op_done got=%b exp=01", {cmd_err, cmd_ready}); end
    ant = 8'hFF; tick();
    ant = 8'h00; tick();
    checks++;
    if (fail_o !== 8'h01) begin failures++; $display("FAIL bad_op_state got=%h exp=01", fail_o); end
  endtask

  task automatic test_reset_wait();
    send(4'd4, 2'd0, 8'h00, 8'd10);
    repeat (3) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_wait_ready got=%b exp=1", cmd_ready); end
    repeat (15) tick();
    ant = 8'hFF; tick();
    ant = 8'h00; tick();
    checks++;
    if (fail_o !== 8'hF7) begin failures++; $display("FAIL rst_drops_cmd got=%h exp=f7", fail_o); end
    checks++;
    if (rd_cnt !== 4'd1) begin failures++; $display("FAIL rst_cnt got=%0d exp=1", rd_cnt); end
  endtask

  initial begin
    test_reset();
    test_pass_fail();
    test_delay_off();
    test_lock();
    test_dir();
    test_kill_gating();
    test_back_to_back_sat();
    test_bad_op();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
